// File: rtl/onewire_txn_sequencer.sv
// 1-Wire master transaction sequencer: reset pulse, presence handshake, command byte write, rd_len byte reads.
// Optional feature macro: ONEWIRE_CRC8_EN adds a Dallas CRC8 check over all received bits (crc_ok).
module onewire_txn_sequencer #(
  parameter int CLKS_PER_US = 1,
  parameter int T_RSTL      = 480,
  parameter int T_SLOT      = 70,
  parameter int T_LOW1      = 6,
  parameter int T_LOW0      = 60,
  parameter int T_RDS       = 15,
  parameter int T_PRES_TO   = 500,
  parameter int RDCNT_W     = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [7:0]         i_cmd_byte,
  input  logic [RDCNT_W-1:0] i_rd_len,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_no_presence,
  output logic [7:0]         o_rd_data,
  output logic               o_rd_valid,
  output logic               o_bus_low,
  input  logic               i_bus_in,
  output logic               o_en_wait_presence,
  input  logic               i_done_wait_presence,
  input  logic               i_found_presence,
  output logic               o_crc_ok
);

  localparam int US_MAX_A = (T_RSTL > T_PRES_TO) ? T_RSTL : T_PRES_TO;
  localparam int US_MAX   = (US_MAX_A > T_SLOT) ? US_MAX_A : T_SLOT;
  localparam int US_W     = $clog2(US_MAX + 1);
  localparam int PRE_W    = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(CLKS_PER_US - 1);
  localparam logic [US_W-1:0]  RSTL_LAST = US_W'(T_RSTL - 1);
  localparam logic [US_W-1:0]  SLOT_LAST = US_W'(T_SLOT - 1);
  localparam logic [US_W-1:0]  LOW1_LAST = US_W'(T_LOW1 - 1);
  localparam logic [US_W-1:0]  LOW0_LAST = US_W'(T_LOW0 - 1);
  localparam logic [US_W-1:0]  PRES_LAST = US_W'(T_PRES_TO - 1);
  localparam logic [US_W-1:0]  RDS_AT    = US_W'(T_RDS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_LOW,
    S_PRES,
    S_WR_SLOT,
    S_RD_SLOT,
    S_FIN
  } state_t;

  state_t             r_state;
  logic [PRE_W-1:0]   r_pre;
  logic [US_W-1:0]    r_us;
  logic [2:0]         r_bitCnt;
  logic [RDCNT_W-1:0] r_byteCnt;
  logic [RDCNT_W-1:0] r_rdLen;
  logic [7:0]         r_cmd;
  logic [7:0]         r_shift;
  logic [7:0]         r_rdData;
  logic               r_busy;
  logic               r_done;
  logic               r_noPres;
  logic               r_rdValid;
  logic               r_busLow;
  logic               r_enWait;

  logic            w_tick;
  logic [US_W-1:0] w_lowLast;
  logic            w_slotEnd;
  logic            w_lastByte;
  logic            w_sample;

  assign w_tick     = (r_pre == PRE_LAST);
  assign w_lowLast  = r_cmd[0] ? LOW1_LAST : LOW0_LAST;
  assign w_slotEnd  = w_tick && (r_us == SLOT_LAST);
  assign w_lastByte = (r_byteCnt == (r_rdLen - RDCNT_W'(1)));
  assign w_sample   = (r_state == S_RD_SLOT) && w_tick && (r_us == RDS_AT);

  // Phases begin with prescaler and us counter at zero so every duration is exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pre     <= '0;
      r_us      <= '0;
      r_bitCnt  <= '0;
      r_byteCnt <= '0;
      r_rdLen   <= '0;
      r_cmd     <= '0;
      r_shift   <= '0;
      r_rdData  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_noPres  <= 1'b0;
      r_rdValid <= 1'b0;
      r_busLow  <= 1'b0;
      r_enWait  <= 1'b0;
    end else begin
      r_done    <= 1'b0;
      r_rdValid <= 1'b0;
      r_pre     <= w_tick ? '0 : r_pre + PRE_W'(1);
      if (w_tick) r_us <= r_us + US_W'(1);

      case (r_state)
        S_IDLE: begin
          r_pre <= '0;
          r_us  <= '0;
          if (i_start) begin
            r_cmd     <= i_cmd_byte;
            r_rdLen   <= i_rd_len;
            r_busy    <= 1'b1;
            r_noPres  <= 1'b0;
            r_busLow  <= 1'b1;
            r_bitCnt  <= '0;
            r_byteCnt <= '0;
            r_state   <= S_RST_LOW;
          end
        end

        S_RST_LOW: begin
          if (w_tick && (r_us == RSTL_LAST)) begin
            r_busLow <= 1'b0;
            r_enWait <= 1'b1;
            r_us     <= '0;
            r_state  <= S_PRES;
          end
        end

        S_PRES: begin
          if (i_done_wait_presence) begin
            r_enWait <= 1'b0;
            r_pre    <= '0;
            r_us     <= '0;
            if (i_found_presence) begin
              r_busLow <= 1'b1;
              r_state  <= S_WR_SLOT;
            end else begin
              r_noPres <= 1'b1;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_state  <= S_FIN;
            end
          end else if (w_tick && (r_us == PRES_LAST)) begin
            r_enWait <= 1'b0;
            r_noPres <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_FIN;
          end
        end

        // Current command bit is always r_cmd[0]; the byte shifts right at each slot end.
        S_WR_SLOT: begin
          if (w_tick && (r_us == w_lowLast)) r_busLow <= 1'b0;
          if (w_slotEnd) begin
            r_us  <= '0;
            r_cmd <= {1'b0, r_cmd[7:1]};
            if (r_bitCnt == 3'd7) begin
              r_bitCnt <= '0;
              if (r_rdLen == '0) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_FIN;
              end else begin
                r_busLow <= 1'b1;
                r_state  <= S_RD_SLOT;
              end
            end else begin
              r_bitCnt <= r_bitCnt + 3'd1;
              r_busLow <= 1'b1;
            end
          end
        end

        S_RD_SLOT: begin
          if (w_tick && (r_us == LOW1_LAST)) r_busLow <= 1'b0;
          if (w_sample) r_shift <= {i_bus_in, r_shift[7:1]};
          if (w_slotEnd) begin
            r_us     <= '0;
            r_bitCnt <= r_bitCnt + 3'd1;
            if (r_bitCnt == 3'd7) begin
              r_rdData  <= r_shift;
              r_rdValid <= 1'b1;
              r_byteCnt <= r_byteCnt + RDCNT_W'(1);
              if (w_lastByte) begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_FIN;
              end else begin
                r_busLow <= 1'b1;
              end
            end else begin
              r_busLow <= 1'b1;
            end
          end
        end

        S_FIN: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef ONEWIRE_CRC8_EN
  logic [7:0] r_crc;
  logic       r_crcOk;
  logic       w_fb;
  logic [7:0] w_crcNext;
  logic       w_startAcc;
  logic       w_rdFinish;

  assign w_fb       = r_crc[0] ^ i_bus_in;
  assign w_crcNext  = {1'b0, r_crc[7:1]} ^ (w_fb ? 8'h8C : 8'h00);
  assign w_startAcc = (r_state == S_IDLE) && i_start;
  assign w_rdFinish = (r_state == S_RD_SLOT) && w_slotEnd && (r_bitCnt == 3'd7) && w_lastByte;

  // Reflected x^8+x^5+x^4+1 fed with the same bit that enters the shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc   <= '0;
      r_crcOk <= 1'b0;
    end else if (w_startAcc) begin
      r_crc   <= '0;
      r_crcOk <= 1'b0;
    end else begin
      if (w_sample) r_crc <= w_crcNext;
      if (w_rdFinish) r_crcOk <= (r_crc == 8'h00);
    end
  end

  assign o_crc_ok = r_crcOk;
`else
  assign o_crc_ok = 1'b0;
`endif

  assign o_busy             = r_busy;
  assign o_done             = r_done;
  assign o_no_presence      = r_noPres;
  assign o_rd_data          = r_rdData;
  assign o_rd_valid         = r_rdValid;
  assign o_bus_low          = r_busLow;
  assign o_en_wait_presence = r_enWait;

endmodule

// File: tb/tb_onewire_txn_sequencer.sv
// Directed bench for onewire_txn_sequencer with a bus slave model and a presence-waiter stand-in.
`timescale 1ns/1ps
module tb_onewire_txn_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] cmdByte;
  logic [3:0] rdLen;
  logic       busy, done, noPres, rdValid, busLow, enWait, crcOk;
  logic [7:0] rdData;
  logic       busIn;
  logic       doneWait, foundPres;
  logic       slaveLow = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  int         lowRun = 0;
  int         lowLens[$];
  int         riseCyc[$];
  logic [7:0] rdBytes[$];
  logic       slaveBits[$];
  int         doneCnt = 0;
  int         rdSkip = 0;
  int         holdCnt = 0;
  logic       prevLow = 1'b0;
  logic       overlap = 1'b0;

  assign busIn = ~busLow & ~slaveLow;

  onewire_txn_sequencer dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .i_start              (start),
    .i_cmd_byte           (cmdByte),
    .i_rd_len             (rdLen),
    .o_busy               (busy),
    .o_done               (done),
    .o_no_presence        (noPres),
    .o_rd_data            (rdData),
    .o_rd_valid           (rdValid),
    .o_bus_low            (busLow),
    .i_bus_in             (busIn),
    .o_en_wait_presence   (enWait),
    .i_done_wait_presence (doneWait),
    .i_found_presence     (foundPres),
    .o_crc_ok             (crcOk)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor and slave: records low pulses, slot starts, received bytes; pulls low for 0-bits.
  always @(negedge clk) begin
    if (busLow) lowRun++;
    else if (lowRun != 0) begin
      lowLens.push_back(lowRun);
      lowRun = 0;
    end
    if (busLow && enWait) overlap = 1'b1;
    if (rdValid) rdBytes.push_back(rdData);
    if (done) doneCnt++;
    if (busLow && !prevLow) begin
      riseCyc.push_back(cyc);
      if (rdSkip > 0) rdSkip--;
      else if (slaveBits.size() > 0) begin
        slaveLow = ~slaveBits.pop_front();
        holdCnt = 40;
      end
    end else if (holdCnt > 0) begin
      holdCnt--;
      if (holdCnt == 0) slaveLow = 1'b0;
    end
    prevLow = busLow;
  end

  initial begin
    #3ms;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic clearMon();
    @(posedge clk);
    lowLens.delete();
    riseCyc.delete();
    rdBytes.delete();
    slaveBits.delete();
    doneCnt = 0;
    lowRun = 0;
    rdSkip = 0;
  endtask

  task automatic doStart(input logic [7:0] c, input logic [3:0] n);
    @(negedge clk);
    cmdByte = c;
    rdLen = n;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitEn(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 700; i++) begin
      if (enWait) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic waitDone(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic presencePulse(input logic found);
    doneWait = 1'b1;
    foundPres = found;
    @(negedge clk);
    doneWait = 1'b0;
    foundPres = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    cmdByte = 8'h00;
    rdLen = 4'd0;
    doneWait = 1'b0;
    foundPres = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %0b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL rst_done: got %0b want 0", done); end
    total++; if (noPres !== 1'b0) begin bad++; $display("[TB] FAIL rst_nopres: got %0b want 0", noPres); end
    total++; if (rdData !== 8'h00) begin bad++; $display("[TB] FAIL rst_rddata: got %h want 00", rdData); end
    total++; if ({rdValid, busLow, enWait, crcOk} !== 4'b0000) begin
      bad++; $display("[TB] FAIL rst_flags: got %b want 0000", {rdValid, busLow, enWait, crcOk});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write_cc();
    bit ok;
    int enCyc, got;
    int expLow[8] = '{60, 60, 6, 6, 60, 60, 6, 6};
    clearMon();
    doStart(8'hCC, 4'd0);
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL wr_busy: got %0b want 1", busy); end
    waitEn(ok);
    enCyc = cyc;
    total++; if (!ok) begin bad++; $display("[TB] FAIL wr_en_wait: got 0 want 1"); end
    got = (riseCyc.size() == 1) ? enCyc - riseCyc[0] : -1;
    total++; if (got !== 480) begin bad++; $display("[TB] FAIL wr_rst_to_en: got %0d want 480", got); end
    total++; if (busLow !== 1'b0) begin bad++; $display("[TB] FAIL wr_release: got %0b want 0", busLow); end
    presencePulse(1'b1);
    waitDone(1000, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL wr_done: got 0 want 1"); end
    total++; if (busy !== 1'b0 || noPres !== 1'b0) begin
      bad++; $display("[TB] FAIL wr_end_flags: got busy=%0b nopres=%0b want 0 0", busy, noPres);
    end
    repeat (3) @(negedge clk);
    total++; if (lowLens.size() !== 9) begin bad++; $display("[TB] FAIL wr_pulse_count: got %0d want 9", lowLens.size()); end
    got = (lowLens.size() > 0) ? lowLens[0] : -1;
    total++; if (got !== 480) begin bad++; $display("[TB] FAIL wr_rst_len: got %0d want 480", got); end
    for (int i = 0; i < 8; i++) begin
      got = (i + 1 < lowLens.size()) ? lowLens[i+1] : -1;
      total++; if (got !== expLow[i]) begin bad++; $display("[TB] FAIL wr_low_bit%0d: got %0d want %0d", i, got, expLow[i]); end
    end
    for (int i = 0; i < 7; i++) begin
      got = (i + 2 < riseCyc.size()) ? riseCyc[i+2] - riseCyc[i+1] : -1;
      total++; if (got !== 70) begin bad++; $display("[TB] FAIL wr_slot%0d_period: got %0d want 70", i, got); end
    end
    total++; if (doneCnt !== 1) begin bad++; $display("[TB] FAIL wr_done_cycles: got %0d want 1", doneCnt); end
  endtask

  task automatic test_no_presence();
    bit ok;
    clearMon();
    doStart(8'hF0, 4'd3);
    waitEn(ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL np_en_wait: got 0 want 1"); end
    presencePulse(1'b0);
    total++; if (done !== 1'b1 || noPres !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL np_finish: got done=%0b nopres=%0b busy=%0b want 1 1 0", done, noPres, busy);
    end
    repeat (5) @(negedge clk);
    total++; if (lowLens.size() !== 1 || riseCyc.size() !== 1) begin
      bad++; $display("[TB] FAIL np_no_slots: got pulses=%0d want 1", lowLens.size());
    end
    total++; if (doneCnt !== 1) begin bad++; $display("[TB] FAIL np_done_cycles: got %0d want 1", doneCnt); end
  endtask

  task automatic test_timeout();
    bit ok;
    int enCyc, got;
    clearMon();
    doStart(8'hA5, 4'd1);
    waitEn(ok);
    enCyc = cyc;
    waitDone(700, ok);
    got = cyc - enCyc;
    total++; if (!ok) begin bad++; $display("[TB] FAIL to_done: got 0 want 1"); end
    total++; if (got !== 500) begin bad++; $display("[TB] FAIL to_duration: got %0d want 500", got); end
    total++; if (noPres !== 1'b1 || enWait !== 1'b0) begin
      bad++; $display("[TB] FAIL to_flags: got nopres=%0b en=%0b want 1 0", noPres, enWait);
    end
    repeat (4) @(negedge clk);
    total++; if (noPres !== 1'b1) begin bad++; $display("[TB] FAIL to_sticky: got %0b want 1", noPres); end
    total++; if (lowLens.size() !== 1) begin bad++; $display("[TB] FAIL to_no_slots: got %0d want 1", lowLens.size()); end
  endtask

  task automatic test_read();
    bit ok;
    int got, shortLows;
    logic [7:0] vals[2];
    int expLow[8] = '{6, 6, 60, 60, 6, 6, 60, 60};
    clearMon();
    vals[0] = 8'hA5;
    vals[1] = 8'h3C;
    rdSkip = 9;
    for (int b = 0; b < 2; b++)
      for (int i = 0; i < 8; i++) slaveBits.push_back(vals[b][i]);
    doStart(8'h33, 4'd2);
    total++; if (noPres !== 1'b0) begin bad++; $display("[TB] FAIL rd_nopres_clear: got %0b want 0", noPres); end
    waitEn(ok);
    presencePulse(1'b1);
    repeat (300) @(negedge clk);
    doStart(8'hFF, 4'd0);
    waitDone(3000, ok);
    total++; if (!ok) begin bad++; $display("[TB] FAIL rd_done: got 0 want 1"); end
    repeat (3) @(negedge clk);
    total++; if (rdBytes.size() !== 2) begin bad++; $display("[TB] FAIL rd_valid_count: got %0d want 2", rdBytes.size()); end
    got = (rdBytes.size() > 0) ? int'(rdBytes[0]) : -1;
    total++; if (got !== 'hA5) begin bad++; $display("[TB] FAIL rd_byte0: got %0h want a5", got); end
    got = (rdBytes.size() > 1) ? int'(rdBytes[1]) : -1;
    total++; if (got !== 'h3C) begin bad++; $display("[TB] FAIL rd_byte1: got %0h want 3c", got); end
    total++; if (rdData !== 8'h3C) begin bad++; $display("[TB] FAIL rd_data_hold: got %h want 3c", rdData); end
    total++; if (lowLens.size() !== 25) begin bad++; $display("[TB] FAIL rd_pulse_count: got %0d want 25", lowLens.size()); end
    for (int i = 0; i < 8; i++) begin
      got = (i + 1 < lowLens.size()) ? lowLens[i+1] : -1;
      total++; if (got !== expLow[i]) begin bad++; $display("[TB] FAIL rd_cmd_bit%0d: got %0d want %0d", i, got, expLow[i]); end
    end
    shortLows = 0;
    for (int i = 9; i < lowLens.size(); i++) if (lowLens[i] == 6) shortLows++;
    total++; if (shortLows !== 16) begin bad++; $display("[TB] FAIL rd_slot_lows: got %0d want 16", shortLows); end
    repeat (20) @(negedge clk);
    total++; if (doneCnt !== 1 || busy !== 1'b0 || lowLens.size() !== 25) begin
      bad++; $display("[TB] FAIL rd_start_ignored: got done=%0d busy=%0b pulses=%0d want 1 0 25", doneCnt, busy, lowLens.size());
    end
    total++; if (overlap !== 1'b0) begin bad++; $display("[TB] FAIL en_bus_overlap: got 1 want 0"); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    clearMon();
    doStart(8'h00, 4'd0);
    waitEn(ok);
    presencePulse(1'b1);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (riseCyc.size() >= 5) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++; if (!ok) begin bad++; $display("[TB] FAIL rm_reach_bit3: got 0 want 1"); end
    repeat (10) @(negedge clk);
    total++; if (busLow !== 1'b1) begin bad++; $display("[TB] FAIL rm_in_low: got %0b want 1", busLow); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (busLow !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL rm_async: got buslow=%0b busy=%0b want 0 0", busLow, busy);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (doneCnt !== 0 || busLow !== 1'b0 || enWait !== 1'b0) begin
      bad++; $display("[TB] FAIL rm_quiet: got done=%0d buslow=%0b en=%0b want 0 0 0", doneCnt, busLow, enWait);
    end
  endtask

`ifdef ONEWIRE_CRC8_EN
  function automatic logic [7:0] crc8Byte(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 8'h8C;
      else c = c >> 1;
    end
    return c;
  endfunction

  task automatic test_crc();
    bit ok;
    logic [7:0] rom[8];
    logic [7:0] c;
    rom[0] = 8'h28; rom[1] = 8'hAD; rom[2] = 8'h01; rom[3] = 8'h4B;
    rom[4] = 8'h00; rom[5] = 8'h00; rom[6] = 8'h00;
    c = 8'h00;
    for (int i = 0; i < 7; i++) c = crc8Byte(c, rom[i]);
    rom[7] = c;
    for (int pass = 0; pass < 2; pass++) begin
      clearMon();
      if (pass == 1) rom[3] = rom[3] ^ 8'h04;
      rdSkip = 9;
      for (int b = 0; b < 8; b++)
        for (int i = 0; i < 8; i++) slaveBits.push_back(rom[b][i]);
      doStart(8'h33, 4'd8);
      total++; if (crcOk !== 1'b0) begin bad++; $display("[TB] FAIL crc_clear%0d: got %0b want 0", pass, crcOk); end
      waitEn(ok);
      presencePulse(1'b1);
      waitDone(6000, ok);
      total++; if (!ok || rdBytes.size() !== 8) begin
        bad++; $display("[TB] FAIL crc_read%0d: got bytes=%0d want 8", pass, rdBytes.size());
      end
      total++; if (crcOk !== (pass == 0)) begin
        bad++; $display("[TB] FAIL crc_ok%0d: got %0b want %0b", pass, crcOk, pass == 0);
      end
      repeat (3) @(negedge clk);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_cc();
    test_no_presence();
    test_timeout();
    test_read();
    test_reset_mid();
`ifdef ONEWIRE_CRC8_EN
    test_crc();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
